// File: rtl/fp_mul_post.sv
// Purpose: post-multiply correction for IEEE-754 single products (special cases, exponent fix, over/underflow); optional sticky flags under FP_MUL_POST_STICKY_EN.
// Latency: 2 cycles from input accept to out_valid_o (S1 classify, S2 resolve/output), 1 result per cycle.
// Backpressure: S2 holds while out_valid_o && !out_ready_i; in_ready_o drops only when S1 is full and S2 cannot advance.
module fp_mul_post #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] dataA_i,
   input  logic [DATA_WIDTH-1:0] dataB_i,
   input  logic [DATA_WIDTH-1:0] prod_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [2:0]            flags_o,
   output logic [2:0]            sticky_o,
   input  logic                  flag_clr_i
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   // flag bit positions within flags_o / sticky_o
   localparam int FLAG_INV = 2;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_UNF = 0;

   // ---------------- S1 input classification ----------------
   logic [7:0]        expA, expB;
   logic              zeroA, zeroB, infA, infB, nanA, nanB;
   logic              invalidIn, infIn, zeroIn;
   logic signed [9:0] baseIn;
   logic              accept;

   assign expA  = dataA_i[30:23];
   assign expB  = dataB_i[30:23];
   // exponent 0 means zero: denormals are flushed
   assign zeroA = (expA == 8'h00);
   assign zeroB = (expB == 8'h00);
   assign infA  = (expA == 8'hFF) && (dataA_i[22:0] == 23'd0);
   assign infB  = (expB == 8'hFF) && (dataB_i[22:0] == 23'd0);
   assign nanA  = (expA == 8'hFF) && (dataA_i[22:0] != 23'd0);
   assign nanB  = (expB == 8'hFF) && (dataB_i[22:0] != 23'd0);

   assign invalidIn = nanA || nanB || (infA && zeroB) || (zeroA && infB);
   assign infIn     = infA || infB;
   assign zeroIn    = zeroA || zeroB;
   assign baseIn    = $signed({2'b00, expA}) + $signed({2'b00, expB}) - 10'sd127;

   logic              s1Valid;
   logic              s1Sign, s1Invalid, s1Inf, s1Zero;
   logic signed [9:0] s1Base;
   logic [30:0]       s1Prod;

   logic              s2Advance;

   assign s2Advance  = !out_valid_o || out_ready_i;
   assign in_ready_o = !s1Valid || s2Advance;
   assign accept     = in_valid_i && in_ready_o;

   // S1 register: capture classified operands and raw product on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid   <= 1'b0;
         s1Sign    <= 1'b0;
         s1Invalid <= 1'b0;
         s1Inf     <= 1'b0;
         s1Zero    <= 1'b0;
         s1Base    <= '0;
         s1Prod    <= '0;
      end else begin
         if (accept) begin
            s1Valid   <= 1'b1;
            s1Sign    <= dataA_i[31] ^ dataB_i[31];
            s1Invalid <= invalidIn;
            s1Inf     <= infIn;
            s1Zero    <= zeroIn;
            s1Base    <= baseIn;
            s1Prod    <= prod_i[30:0];
         end else if (s2Advance) begin
            s1Valid   <= 1'b0;
         end
      end
   end

   // ---------------- S2 resolution ----------------
   // The product exponent wraps mod 256; its offset from the base tells
   // whether the multiplier normalised by one extra bit.
   logic [7:0]        normDiff;
   logic              norm;
   logic signed [9:0] expTrue;
   logic [31:0]       resData;
   logic [2:0]        resFlags;

   assign normDiff = s1Prod[30:23] - s1Base[7:0];
   assign norm     = normDiff[0];
   assign expTrue  = s1Base + $signed({9'd0, norm});

   // strict-priority special-case resolution, at most one flag set
   always_comb begin
      resData  = {s1Sign, expTrue[7:0], s1Prod[22:0]};
      resFlags = 3'b000;
      if (s1Invalid) begin
         resData            = QNAN;
         resFlags[FLAG_INV] = 1'b1;
      end else if (s1Inf) begin
         resData = {s1Sign, 8'hFF, 23'd0};
      end else if (s1Zero) begin
         resData = {s1Sign, 31'd0};
      end else if (expTrue >= 10'sd255) begin
         resData            = {s1Sign, 8'hFF, 23'd0};
         resFlags[FLAG_OVF] = 1'b1;
      end else if (expTrue <= 10'sd0) begin
         resData            = {s1Sign, 31'd0};
         resFlags[FLAG_UNF] = 1'b1;
      end
   end

   // S2 output register: load whenever the consumer is not stalling us
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_o <= 1'b0;
         data_o      <= '0;
         flags_o     <= 3'b000;
      end else if (s2Advance) begin
         out_valid_o <= s1Valid;
         if (s1Valid) begin
            data_o  <= resData;
            flags_o <= resFlags;
         end
      end
   end

   logic outHandshake;
   assign outHandshake = out_valid_o && out_ready_i;

   // sign bit of the raw product is not needed; the result sign comes from the operands
   logic unusedProdSign;
   assign unusedProdSign = prod_i[31];

`ifdef FP_MUL_POST_STICKY_EN
   logic [2:0] stickyQ;

   // sticky accumulation; a clear keeps only the flags delivered on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stickyQ <= 3'b000;
      end else if (flag_clr_i) begin
         stickyQ <= outHandshake ? flags_o : 3'b000;
      end else if (outHandshake) begin
         stickyQ <= stickyQ | flags_o;
      end
   end

   assign sticky_o = stickyQ;
`else
   logic unusedStickyInputs;
   assign unusedStickyInputs = flag_clr_i ^ outHandshake;
   assign sticky_o           = 3'b000;
`endif

endmodule

// File: tb/tb_fp_mul_post.sv
// Scoreboard bench for fp_mul_post: directed vectors with hand-computed results,
// expectations queued at accept and checked by an independent output monitor,
// plus backpressure, reset and sticky-flag scenarios.
module tb_fp_mul_post;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [31:0] prod = '0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] dataOut;
   logic [2:0]  flagsOut;
   logic [2:0]  stickyOut;
   logic        flagClr = 1'b0;

   int checks = 0;
   int passes = 0;

   logic [34:0] expQ[$];
   logic [34:0] pending;

   fp_mul_post #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady),
      .dataA_i     (dataA),
      .dataB_i     (dataB),
      .prod_i      (prod),
      .out_valid_o (outValid),
      .out_ready_i (outReady),
      .data_o      (dataOut),
      .flags_o     (flagsOut),
      .sticky_o    (stickyOut),
      .flag_clr_i  (flagClr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a triple; the expected result is remembered until accept
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic [31:0] ed, input logic [2:0] ef);
      dataA   = a;
      dataB   = b;
      prod    = p;
      inValid = 1'b1;
      pending = {ef, ed};
   endtask

   task automatic waitAccept();
      bit done = 0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (inReady) begin
            expQ.push_back(pending);
            done = 1;
         end
      end
      if (!done) check("accept_timeout", 32'd0, 32'd1);
      tick();
      inValid = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] ed, input logic [2:0] ef);
      drive(a, b, p, ed, ef);
      waitAccept();
   endtask

   task automatic drain();
      bit done = 0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (expQ.size() == 0) done = 1;
      end
      if (!done) check("drain_timeout", 32'(expQ.size()), 32'd0);
      tick();
   endtask

   task automatic pulseClear();
      flagClr = 1'b1;
      tick();
      flagClr = 1'b0;
   endtask

   // monitor: every completed output handshake is compared with the queue head
   always @(negedge clk) begin
      logic [34:0] e;
      if (!rst && outValid && outReady) begin
         if (expQ.size() == 0) begin
            check("unexpected_output", dataOut, 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            check("data_o", dataOut, e[31:0]);
            check("flags_o", {29'd0, flagsOut}, {29'd0, e[34:32]});
         end
      end
   end

   initial begin
      // reset values are forced without any clock edge
      #2;
      check("rst_out_valid", {31'd0, outValid}, 32'd0);
      check("rst_data", dataOut, 32'd0);
      check("rst_flags", {29'd0, flagsOut}, 32'd0);
      check("rst_sticky", {29'd0, stickyOut}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'd0, inReady}, 32'd1);
      tick();

      // main function, back-to-back with the consumer always ready
      outReady = 1'b1;
      send(32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 3'b000); // 2*3
      send(32'hC0000000, 32'h40400000, 32'h40C00000, 32'hC0C00000, 3'b000); // -2*3
      send(32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b010); // overflow
      send(32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 3'b001); // underflow E=0
      send(32'h7F800000, 32'h00000000, 32'h12345678, 32'h7FC00000, 3'b100); // inf*0
      send(32'h00000000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 3'b100); // 0*-inf
      send(32'h7FC00001, 32'h3F800000, 32'h00000000, 32'h7FC00000, 3'b100); // NaN
      send(32'hFF800000, 32'h40000000, 32'h00000000, 32'hFF800000, 3'b000); // -inf*2
      send(32'h80000000, 32'h40000000, 32'h00000000, 32'h80000000, 3'b000); // -0*2
      send(32'h00000001, 32'h3F800000, 32'h00000000, 32'h00000000, 3'b000); // denormal flush
      send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 3'b000); // norm=1
      send(32'h7F400000, 32'h3FC00000, 32'h7F900000, 32'h7F800000, 3'b010); // E=255 via norm
      send(32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 3'b000); // E=1 boundary
      send(32'h00800000, 32'h00800000, 32'h41800000, 32'h00000000, 3'b001); // negative base
      drain();

      // backpressure: two accepts fill the pipe, the third waits
      outReady = 1'b0;
      send(32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 3'b000);
      send(32'hC0000000, 32'h40400000, 32'h40C00000, 32'hC0C00000, 3'b000);
      drive(32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b010);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", {31'd0, inReady}, 32'd0);
         check("stall_hold_data", dataOut, 32'h40C00000);
         check("stall_hold_valid", {31'd0, outValid}, 32'd1);
      end
      tick();
      outReady = 1'b1;
      waitAccept();
      drain();
      check("order_all_popped", 32'(expQ.size()), 32'd0);

`ifdef FP_MUL_POST_STICKY_EN
      pulseClear();
      @(negedge clk);
      check("sticky_clr0", {29'd0, stickyOut}, 32'd0);
      tick();
      send(32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b010);
      drain();
      @(negedge clk);
      check("sticky_ovf", {29'd0, stickyOut}, 32'h2);
      tick();
      pulseClear();
      @(negedge clk);
      check("sticky_clr", {29'd0, stickyOut}, 32'd0);
      tick();
      send(32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 3'b010);
      drain();
      // hold the underflow result, then release it on the same edge as a clear
      outReady = 1'b0;
      send(32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 3'b001);
      begin
         bit seen = 0;
         for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (outValid) seen = 1;
         end
         if (!seen) check("sticky_wait_timeout", 32'd0, 32'd1);
      end
      tick();
      check("sticky_before_coincide", {29'd0, stickyOut}, 32'h2);
      outReady = 1'b1;
      flagClr  = 1'b1;
      tick();
      flagClr  = 1'b0;
      @(negedge clk);
      check("sticky_coincide", {29'd0, stickyOut}, 32'h1);
      tick();
`else
      flagClr = 1'b1;
      tick();
      flagClr = 1'b0;
      check("sticky_tied", {29'd0, stickyOut}, 32'd0);
`endif

      // reset mid-operation discards the held item
      outReady = 1'b0;
      send(32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 3'b000);
      tick();
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, outValid}, 32'd0);
      check("midrst_data", dataOut, 32'd0);
      check("midrst_sticky", {29'd0, stickyOut}, 32'd0);
      expQ.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ready", {31'd0, inReady}, 32'd1);
      check("midrst_no_output", {31'd0, outValid}, 32'd0);
      tick();
      outReady = 1'b1;
      send(32'hC0000000, 32'h40400000, 32'h40C00000, 32'hC0C00000, 3'b000);
      drain();
      check("final_queue_empty", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
